// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM gate sequencing logic: controller state
// encoding, gate index constants and the element/timestep address width.
package lstm_pkg;

   localparam int ADDR_W = 8;

   localparam logic [1:0] GATE_F = 2'd0;
   localparam logic [1:0] GATE_I = 2'd1;
   localparam logic [1:0] GATE_C = 2'd2;
   localparam logic [1:0] GATE_O = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/lstm_elem_cnt.sv
// Wrapping modulo-MAX counter with enable and clear. The count holds whenever
// en is low, which is how a consumer stall freezes sequencing. tc flags the
// terminal value MAX-1 combinationally so the caller can act on the wrap edge.
module lstm_elem_cnt
   import lstm_pkg::*;
#(
   parameter int MAX = 30,
   parameter int W   = ADDR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   assign tc = (cnt == W'(MAX - 1));

   // Count up on enable, wrapping MAX-1 -> 0; reset and clear both return to 0.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/lstm_gate_sched.sv
// Sequencing controller for the LSTM gate weight buffers. Each timestep it
// streams INPUT_SIZE read strobes to every gate buffer in order, driving the
// shared MAC's input address and clear/valid/last controls alongside, then
// spends one DONE cycle reporting step/sequence completion.
// Per-element strobes (r_en, mac_*) are decoded from registered state and
// the live hold input, so a stall suppresses them in the very cycle it is seen.
module lstm_gate_sched
   import lstm_pkg::*;
#(
   parameter int INPUT_SIZE = 30,
   parameter int GATES      = 4,
   parameter int SEQ_LEN    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              hold,
   output logic [GATES-1:0]  r_en,
   output logic [1:0]        gate_sel,
   output logic [ADDR_W-1:0] x_addr,
   output logic [ADDR_W-1:0] t_idx,
   output logic              mac_clr,
   output logic              mac_valid,
   output logic              mac_last,
   output logic              gate_done,
   output logic              step_done,
   output logic              seq_done,
   output logic              busy
);

   if (GATES < 1 || GATES > 4) begin : g_bad_gates
      $error("lstm_gate_sched: GATES must be 1..4 (gate_sel is 2 bits)");
   end
   if (INPUT_SIZE < 2 || INPUT_SIZE > 255) begin : g_bad_input_size
      $error("lstm_gate_sched: INPUT_SIZE must be 2..255");
   end
   if (SEQ_LEN < 1 || SEQ_LEN > 256) begin : g_bad_seq_len
      $error("lstm_gate_sched: SEQ_LEN must be 1..256");
   end

   state_t     state;
   logic [1:0] gate_q;
   logic       adv;
   logic       elem_tc;
   logic       t_tc;
   logic       last_gate;

   // An element is consumed only in RUN with no stall; every counter keys off this.
   assign adv       = (state == ST_RUN) && !hold;
   assign last_gate = (gate_q == 2'(GATES - 1));

   lstm_elem_cnt #(.MAX(INPUT_SIZE), .W(ADDR_W)) u_elem_cnt (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .en  (adv),
      .cnt (x_addr),
      .tc  (elem_tc)
   );

   lstm_elem_cnt #(.MAX(SEQ_LEN), .W(ADDR_W)) u_step_cnt (
      .clk (clk),
      .rst (rst),
      .clr (1'b0),
      .en  (state == ST_DONE),
      .cnt (t_idx),
      .tc  (t_tc)
   );

   assign gate_sel  = gate_q;
   assign r_en      = adv ? (GATES'(1) << gate_q) : '0;
   assign mac_valid = adv;
   assign mac_clr   = adv && (x_addr == '0);
   assign mac_last  = adv && elem_tc;

   // Controller FSM with registered gate index and completion pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         gate_q    <= GATE_F;
         gate_done <= 1'b0;
         step_done <= 1'b0;
         seq_done  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         gate_done <= adv && elem_tc;
         step_done <= 1'b0;
         seq_done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (adv && elem_tc) begin
                  if (last_gate) begin
                     state     <= ST_DONE;
                     gate_q    <= GATE_F;
                     step_done <= 1'b1;
                     seq_done  <= t_tc;
                  end else begin
                     gate_q <= gate_q + 2'd1;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
